// File: rtl/booth_seq_mult_ctrl.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready in and out.
// Define BOOTH_SEQ_EARLY_TERM_EN to stop as soon as all remaining digits are zero.
module booth_seq_mult_ctrl #(
   parameter int A_W = 24,
   parameter int B_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     in_a,
   input  logic [B_W-1:0]     in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W+B_W-1:0] out_p,
   output logic               busy
);

   localparam int P_W   = A_W + B_W;
   localparam int STEPS = B_W / 2;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_DONE
   } state_t;

   state_t         r_state;
   logic [A_W-1:0] r_a;
   logic [B_W-1:0] r_b;
   logic [P_W-1:0] r_acc;
   logic [SW-1:0]  r_step;

   logic [B_W:0]   w_bext;
   logic [2:0]     w_trip;
   logic [P_W-1:0] w_aext;
   logic [P_W-1:0] w_mag;
   logic [P_W-1:0] w_pp;
   logic [P_W-1:0] w_ppsh;
   logic [P_W-1:0] w_sum;
   logic           w_last;

   assign w_bext = {r_b, 1'b0};
   assign w_trip = w_bext[{r_step, 1'b0} +: 3];
   assign w_aext = {{B_W{r_a[A_W-1]}}, r_a};

   always_comb begin
      w_mag = '0;
      unique case (w_trip)
         3'b001, 3'b010,
         3'b101, 3'b110: w_mag = w_aext;
         3'b011, 3'b100: w_mag = w_aext << 1;
         default:        w_mag = '0;
      endcase
   end

   // 111 negates a zero magnitude, which stays exactly zero
   assign w_pp   = w_trip[2] ? (~w_mag + P_W'(1)) : w_mag;
   assign w_ppsh = w_pp << {r_step, 1'b0};
   assign w_sum  = r_acc + w_ppsh;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
   logic [B_W-1:0] w_hi;
   // bits above the current digit all equal -> remaining digits are zero
   assign w_hi   = B_W'($signed(r_b) >>> {r_step, 1'b1});
   assign w_last = (w_hi == '0) || (w_hi == '1)
                || (r_step == SW'(STEPS - 1));
`else
   assign w_last = (r_step == SW'(STEPS - 1));
`endif

   assign out_p = r_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_step    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a      <= in_a;
                  r_b      <= in_b;
                  r_acc    <= '0;
                  r_step   <= '0;
                  r_state  <= S_ITER;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_ITER: begin
               r_acc  <= w_sum;
               r_step <= r_step + SW'(1);
               if (w_last) begin
                  r_state   <= S_DONE;
                  out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state   <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed bench for booth_seq_mult_ctrl; latencies follow BOOTH_SEQ_EARLY_TERM_EN.
module tb_booth_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_p;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   booth_seq_mult_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
   localparam int L5  = 2;
   localparam int L7  = 2;
   localparam int L3  = 2;
   localparam int L1  = 1;
   localparam int LFF = 1;
`else
   localparam int L5  = 4;
   localparam int L7  = 4;
   localparam int L3  = 4;
   localparam int L1  = 4;
   localparam int LFF = 4;
`endif

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [23:0] a,
                         input logic [7:0] b, input logic [31:0] exp,
                         input int lat, input int hold);
      int k;
      logic [31:0] p0;
      check({tag, "_pre_ready"}, in_ready, 1'b1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_ready_lo"}, in_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      check({tag, "_lat"}, k, lat);
      check({tag, "_p"}, out_p, exp);
      check({tag, "_ready_done"}, in_ready, 1'b0);
      p0 = out_p;
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         in_a     = 24'h000123 + i;
         in_b     = 8'h11;
         @(posedge clk);
         @(negedge clk);
         check({tag, "_hold_v"}, out_valid, 1'b1);
         check({tag, "_hold_p"}, out_p, p0);
         check({tag, "_hold_rdy"}, in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_post_v"}, out_valid, 1'b0);
      check({tag, "_post_rdy"}, in_ready, 1'b1);
      check({tag, "_post_busy"}, busy, 1'b0);
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", in_ready, 1'b1);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_p", out_p, 32'h0);
      rst = 1'b0;

      run_op("m3x5", 24'h000003, 8'h05, 32'h0000000F, L5, 0);
      run_op("mn1xn128", 24'hFFFFFF, 8'h80, 32'h00000080, 4, 0);
      run_op("mminxn128", 24'h800000, 8'h80, 32'h40000000, 4, 0);
      run_op("mmaxx7f", 24'h7FFFFF, 8'h7F, 32'h3F7FFF81, 4, 0);
      run_op("m1x7", 24'h000001, 8'h07, 32'h00000007, L7, 0);
      run_op("m9x1", 24'h000009, 8'h01, 32'h00000009, L1, 0);
      run_op("m9xff", 24'h000009, 8'hFF, 32'hFFFFFFF7, LFF, 0);
      run_op("m9x40", 24'h000009, 8'h40, 32'h00000240, 4, 0);
      run_op("bp", 24'h000003, 8'h05, 32'h0000000F, L5, 10);

      @(posedge clk);
      @(negedge clk);
      check("bp_idle_busy", busy, 1'b0);

      in_a     = 24'h000055;
      in_b     = 8'h7F;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ready", in_ready, 1'b1);
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      k = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid || busy) k++;
      end
      check("mid_rst_no_result", k, 0);

      rst      = 1'b1;
      in_valid = 1'b1;
      in_a     = 24'h000004;
      in_b     = 8'h04;
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_vs_valid_busy", busy, 1'b0);
      check("rst_vs_valid_ready", in_ready, 1'b1);

      run_op("m2x3", 24'h000002, 8'h03, 32'h00000006, L3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
